// File: rtl/spi_ram_slave_crc.sv
// spi_ram_slave_crc
//   SPI slave in front of a small register-array RAM. A frame is an 8-bit
//   command (bit 7 = read, low ADDR_W bits = address), DATA_W data bits and
//   an 8-bit CRC-8 (poly 0x1D, init 0xFF), all MSB first. Writes commit only
//   when the received CRC matches the CRC of command + data. Reads return the
//   RAM word followed by the CRC of that word. SCK, CSN and MOSI are
//   asynchronous and are oversampled in the clk domain.
//
// Ports
//   clk, rstn        system clock, asynchronous active-low reset
//   sck, csn, mosi   SPI inputs (asynchronous to clk)
//   miso             slave data out, MSB first, 0 outside read phases
//   miso_oe          pad enable, follows synchronised ~csn
//   frame_done       1-clk pulse when a complete frame is closed by csn rise
//   crc_err          1-clk pulse when a write frame's CRC mismatches
//   abort            1-clk pulse when csn rises mid-frame
//   wr_cnt           committed write count, wraps
//   dbg_state        current FSM state (for checkers)
module spi_ram_slave_crc #(
    parameter int                DATA_W  = 24,
    parameter int                ADDR_W  = 5,
    parameter bit                CPOL    = 1'b0,
    parameter bit                CPHA    = 1'b0,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        sck,
    input  logic        csn,
    input  logic        mosi,
    output logic        miso,
    output logic        miso_oe,
    output logic        frame_done,
    output logic        crc_err,
    output logic        abort,
    output logic [15:0] wr_cnt,
    output logic [2:0]  dbg_state
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_RDLOAD = 3'd2,
        ST_RDATA  = 3'd3,
        ST_RCRC   = 3'd4,
        ST_WDATA  = 3'd5,
        ST_WCRC   = 3'd6,
        ST_WAITCS = 3'd7
    } state_t;

    function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic b);
        crc8_step = (c[7] ^ b) ? ({c[6:0], 1'b0} ^ 8'h1D) : {c[6:0], 1'b0};
    endfunction

    // Synchronisers and edge history
    logic sck_s1_q, sck_s2_q, sck_prev_q;
    logic csn_s1_q, csn_s2_q, csn_prev_q;
    logic mosi_s1_q, mosi_s2_q;

    // Frame state
    state_t              state_q, state_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]          crc_q, crc_d;
    logic [7:0]          cmd_q, cmd_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic [7:0]          rx_crc_q, rx_crc_d;
    logic                miso_q, miso_d;
    logic                pend_q, pend_d;
    logic                miso_oe_q, miso_oe_d;
    logic                frame_done_q, frame_done_d;
    logic                crc_err_q, crc_err_d;
    logic                abort_q, abort_d;
    logic [15:0]         wr_cnt_q, wr_cnt_d;
    logic                wr_en;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic sck_rise, sck_fall, lead_ev, trail_ev, sample_ev, shift_ev;
    logic csn_fall, csn_rise, mid_frame;
    logic [7:0]        crc_mosi, crc_miso, cmd_nxt, rx_crc_nxt;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] rd_word;
    logic              cmd_unused;

    assign sck_rise  = sck_s2_q & ~sck_prev_q;
    assign sck_fall  = ~sck_s2_q & sck_prev_q;
    // Leading edge leaves the idle level; CPHA picks which edge samples.
    assign lead_ev   = CPOL ? sck_fall : sck_rise;
    assign trail_ev  = CPOL ? sck_rise : sck_fall;
    assign sample_ev = CPHA ? trail_ev : lead_ev;
    assign shift_ev  = CPHA ? lead_ev  : trail_ev;

    assign csn_fall  = csn_prev_q & ~csn_s2_q;
    assign csn_rise  = ~csn_prev_q & csn_s2_q;
    assign mid_frame = (state_q != ST_IDLE) && (state_q != ST_WAITCS);

    assign crc_mosi   = crc8_step(crc_q, mosi_s2_q);
    assign crc_miso   = crc8_step(crc_q, miso_q);
    assign cmd_nxt    = {cmd_q[6:0], mosi_s2_q};
    assign rx_crc_nxt = {rx_crc_q[6:0], mosi_s2_q};
    assign addr       = cmd_q[ADDR_W-1:0];
    assign rd_word    = mem_q[addr];
    // Command bits above the address field carry no meaning once decoded.
    assign cmd_unused = ^cmd_q[7:ADDR_W];

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        crc_d        = crc_q;
        cmd_d        = cmd_q;
        shreg_d      = shreg_q;
        rx_crc_d     = rx_crc_q;
        miso_d       = miso_q;
        pend_d       = pend_q;
        wr_cnt_d     = wr_cnt_q;
        miso_oe_d    = ~csn_s2_q;
        frame_done_d = 1'b0;
        crc_err_d    = 1'b0;
        abort_d      = 1'b0;
        wr_en        = 1'b0;

        if (csn_rise && mid_frame) begin
            abort_d = 1'b1;
            miso_d  = 1'b0;
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    miso_d = 1'b0;
                    if (csn_fall) begin
                        bit_cnt_d = '0;
                        crc_d     = 8'hFF;
                        state_d   = ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (sample_ev) begin
                        cmd_d = cmd_nxt;
                        crc_d = crc_mosi;
                        if (bit_cnt_q == CNT_W'(7)) begin
                            bit_cnt_d = '0;
                            state_d   = cmd_nxt[7] ? ST_RDLOAD : ST_WDATA;
                        end else begin
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_RDLOAD: begin
                    // MSB goes straight onto miso; the rest waits in shreg.
                    miso_d    = rd_word[DATA_W-1];
                    shreg_d   = rd_word << 1;
                    crc_d     = 8'hFF;
                    pend_d    = 1'b0;
                    bit_cnt_d = '0;
                    state_d   = ST_RDATA;
                end
                ST_RDATA: begin
                    // pend gates shifting so the edge right after RDLOAD
                    // cannot skip past the MSB before the master sampled it.
                    if (sample_ev) begin
                        crc_d  = crc_miso;
                        pend_d = 1'b1;
                        if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                            shreg_d   = DATA_W'(crc_miso) << (DATA_W - 8);
                            bit_cnt_d = '0;
                            state_d   = ST_RCRC;
                        end else begin
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end else if (shift_ev && pend_q) begin
                        miso_d  = shreg_q[DATA_W-1];
                        shreg_d = shreg_q << 1;
                        pend_d  = 1'b0;
                    end
                end
                ST_RCRC: begin
                    if (sample_ev) begin
                        pend_d = 1'b1;
                        if (bit_cnt_q == CNT_W'(7)) begin
                            miso_d  = 1'b0;
                            state_d = ST_WAITCS;
                        end else begin
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end else if (shift_ev && pend_q) begin
                        miso_d  = shreg_q[DATA_W-1];
                        shreg_d = shreg_q << 1;
                        pend_d  = 1'b0;
                    end
                end
                ST_WDATA: begin
                    if (sample_ev) begin
                        shreg_d = {shreg_q[DATA_W-2:0], mosi_s2_q};
                        crc_d   = crc_mosi;
                        if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                            bit_cnt_d = '0;
                            state_d   = ST_WCRC;
                        end else begin
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_WCRC: begin
                    // crc_q is frozen here: it holds the CRC of cmd + data.
                    if (sample_ev) begin
                        rx_crc_d = rx_crc_nxt;
                        if (bit_cnt_q == CNT_W'(7)) begin
                            if (rx_crc_nxt == crc_q) begin
                                wr_en    = 1'b1;
                                wr_cnt_d = wr_cnt_q + 16'd1;
                            end else begin
                                crc_err_d = 1'b1;
                            end
                            state_d = ST_WAITCS;
                        end else begin
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_WAITCS: begin
                    miso_d = 1'b0;
                    if (csn_rise) begin
                        frame_done_d = 1'b1;
                        state_d      = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sck_s1_q     <= CPOL;
            sck_s2_q     <= CPOL;
            sck_prev_q   <= CPOL;
            csn_s1_q     <= 1'b1;
            csn_s2_q     <= 1'b1;
            csn_prev_q   <= 1'b1;
            mosi_s1_q    <= 1'b0;
            mosi_s2_q    <= 1'b0;
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            crc_q        <= 8'hFF;
            cmd_q        <= '0;
            shreg_q      <= '0;
            rx_crc_q     <= '0;
            miso_q       <= 1'b0;
            pend_q       <= 1'b0;
            miso_oe_q    <= 1'b0;
            frame_done_q <= 1'b0;
            crc_err_q    <= 1'b0;
            abort_q      <= 1'b0;
            wr_cnt_q     <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= RST_VAL;
        end else begin
            sck_s1_q     <= sck;
            sck_s2_q     <= sck_s1_q;
            sck_prev_q   <= sck_s2_q;
            csn_s1_q     <= csn;
            csn_s2_q     <= csn_s1_q;
            csn_prev_q   <= csn_s2_q;
            mosi_s1_q    <= mosi;
            mosi_s2_q    <= mosi_s1_q;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            crc_q        <= crc_d;
            cmd_q        <= cmd_d;
            shreg_q      <= shreg_d;
            rx_crc_q     <= rx_crc_d;
            miso_q       <= miso_d;
            pend_q       <= pend_d;
            miso_oe_q    <= miso_oe_d;
            frame_done_q <= frame_done_d;
            crc_err_q    <= crc_err_d;
            abort_q      <= abort_d;
            wr_cnt_q     <= wr_cnt_d;
            if (wr_en) mem_q[addr] <= shreg_q;
        end
    end

    assign miso       = miso_q;
    assign miso_oe    = miso_oe_q;
    assign frame_done = frame_done_q;
    assign crc_err    = crc_err_q;
    assign abort      = abort_q;
    assign wr_cnt     = wr_cnt_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_spi_ram_slave_crc.sv
// Bench for spi_ram_slave_crc: four builds covering every CPOL/CPHA mode and
// DATA_W 8/16/24/32. Each build has its own SPI master pins; frames are run
// one build at a time and compared against a word-level RAM/CRC model.
module tb_spi_ram_slave_crc;

    localparam int NI = 4;
    localparam int HP = 4;  // SCK half period in clk cycles
    localparam bit          CP_OL [NI] = '{1'b0, 1'b0, 1'b1, 1'b1};
    localparam bit          CP_HA [NI] = '{1'b0, 1'b1, 1'b0, 1'b1};
    localparam int          DW    [NI] = '{24, 16, 32, 8};
    localparam int          AW    [NI] = '{5, 7, 7, 3};
    localparam logic [31:0] RSTV  [NI] = '{32'h0, 32'h0000_A5C3, 32'h0, 32'h0000_003C};

    logic clk = 1'b0;
    logic rstn;
    logic sck_v [NI];
    logic csn_v [NI];
    logic mosi_v [NI];
    logic miso_v [NI];
    logic miso_oe_v [NI];
    logic fd_v [NI];
    logic ce_v [NI];
    logic ab_v [NI];
    logic [15:0] wrc_v [NI];
    logic [2:0]  dbg_v [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        spi_ram_slave_crc #(
            .DATA_W (DW[g]),
            .ADDR_W (AW[g]),
            .CPOL   (CP_OL[g]),
            .CPHA   (CP_HA[g]),
            .RST_VAL(RSTV[g][DW[g]-1:0])
        ) u_dut (
            .clk       (clk),
            .rstn      (rstn),
            .sck       (sck_v[g]),
            .csn       (csn_v[g]),
            .mosi      (mosi_v[g]),
            .miso      (miso_v[g]),
            .miso_oe   (miso_oe_v[g]),
            .frame_done(fd_v[g]),
            .crc_err   (ce_v[g]),
            .abort     (ab_v[g]),
            .wr_cnt    (wrc_v[g]),
            .dbg_state (dbg_v[g])
        );
    end

    // Scoreboard state
    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q [$];
    logic [31:0] exp_mem [NI][128];
    int exp_wr [NI];
    int exp_fd [NI];
    int exp_ce [NI];
    int exp_ab [NI];
    int fd_cnt [NI];
    int ce_cnt [NI];
    int ab_cnt [NI];

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (fd_v[i]) fd_cnt[i]++;
            if (ce_v[i]) ce_cnt[i]++;
            if (ab_v[i]) ab_cnt[i]++;
        end
    end

    initial begin
        repeat (150000) @(posedge clk);
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // CRC-8 poly 0x1D over the n low bits of msg, MSB first.
    function automatic logic [7:0] crc8(input logic [7:0] init, input logic [63:0] msg, input int n);
        logic [7:0] c;
        c = init;
        for (int i = n - 1; i >= 0; i--) begin
            if (c[7] ^ msg[i]) c = {c[6:0], 1'b0} ^ 8'h1D;
            else               c = {c[6:0], 1'b0};
        end
        return c;
    endfunction

    function automatic logic [31:0] dmask(input int idx);
        return (DW[idx] == 32) ? 32'hFFFF_FFFF : 32'((64'd1 << DW[idx]) - 64'd1);
    endfunction

    function automatic logic [7:0] amask(input int idx);
        return 8'((16'd1 << AW[idx]) - 16'd1);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NI; i++) begin
            exp_wr[i] = 0;
            for (int a = 0; a < 128; a++) exp_mem[i][a] = RSTV[i] & dmask(i);
        end
    endfunction

    task automatic check_counts(input int idx);
        check($sformatf("i%0d frame_done_cnt", idx), 32'(fd_cnt[idx]), 32'(exp_fd[idx]));
        check($sformatf("i%0d crc_err_cnt", idx),    32'(ce_cnt[idx]), 32'(exp_ce[idx]));
        check($sformatf("i%0d abort_cnt", idx),      32'(ab_cnt[idx]), 32'(exp_ab[idx]));
        check($sformatf("i%0d wr_cnt", idx),         32'(wrc_v[idx]),  32'(exp_wr[idx]));
        check($sformatf("i%0d state_idle", idx),     32'(dbg_v[idx]),  32'd0);
        check($sformatf("i%0d miso_oe_idle", idx),   32'(miso_oe_v[idx]), 32'd0);
    endtask

    // One SPI frame as master. stop_at < frame length cuts the frame short;
    // rst_mid then pulses rstn instead of just raising csn.
    task automatic spi_frame(input int idx, input logic [7:0] cmd, input logic [31:0] data,
                             input logic [7:0] crc_tx, input int stop_at, input bit rst_mid,
                             output logic [31:0] rx_data, output logic [7:0] rx_crc,
                             output logic rx_any);
        int nb;
        logic [63:0] tx;
        logic [63:0] rx;
        nb = 16 + DW[idx];
        tx = (64'(cmd) << (DW[idx] + 8)) | (64'(data) << 8) | 64'(crc_tx);
        rx = '0;
        csn_v[idx] = 1'b0;
        repeat (HP) @(negedge clk);
        check($sformatf("i%0d miso_oe_active", idx), 32'(miso_oe_v[idx]), 32'd1);
        for (int i = 0; i < nb && i < stop_at; i++) begin
            logic b;
            b = tx[nb-1-i];
            if (!CP_HA[idx]) mosi_v[idx] = b;
            repeat (HP) @(negedge clk);
            if (!CP_HA[idx]) rx[nb-1-i] = miso_v[idx];
            sck_v[idx] = ~CP_OL[idx];
            if (CP_HA[idx]) mosi_v[idx] = b;
            repeat (HP) @(negedge clk);
            if (CP_HA[idx]) rx[nb-1-i] = miso_v[idx];
            sck_v[idx] = CP_OL[idx];
        end
        repeat (HP) @(negedge clk);
        if (rst_mid) begin
            rstn = 1'b0;
            csn_v[idx] = 1'b1;
            repeat (2) @(negedge clk);
            check($sformatf("i%0d rst_miso", idx),    32'(miso_v[idx]),    32'd0);
            check($sformatf("i%0d rst_miso_oe", idx), 32'(miso_oe_v[idx]), 32'd0);
            check($sformatf("i%0d rst_state", idx),   32'(dbg_v[idx]),     32'd0);
            repeat (2) @(negedge clk);
            rstn = 1'b1;
            repeat (4) @(negedge clk);
        end else begin
            csn_v[idx] = 1'b1;
            repeat (8) @(negedge clk);
        end
        mosi_v[idx] = 1'b0;
        rx_data = 32'(rx >> 8) & dmask(idx);
        rx_crc  = rx[7:0];
        rx_any  = |rx;
    endtask

    task automatic do_write(input int idx, input int addr, input logic [31:0] data_in,
                            input bit bad, input int stop_at);
        logic [7:0]  cmd, crc_good, crc_tx, rx_crc;
        logic [31:0] data, rx_data;
        logic        rx_any;
        int          a;
        data = data_in & dmask(idx);
        a = addr & 32'(amask(idx));
        cmd = {1'b0, 7'($urandom)};
        cmd = (cmd & ~amask(idx)) | 8'(a);
        crc_good = crc8(8'hFF, (64'(cmd) << DW[idx]) | 64'(data), 8 + DW[idx]);
        crc_tx = bad ? (crc_good ^ (8'd1 << $urandom_range(0, 7))) : crc_good;
        spi_frame(idx, cmd, data, crc_tx, stop_at, 1'b0, rx_data, rx_crc, rx_any);
        check($sformatf("i%0d wr_miso_quiet", idx), 32'(rx_any), 32'd0);
        if (stop_at < 16 + DW[idx]) begin
            exp_ab[idx]++;
        end else begin
            exp_fd[idx]++;
            if (bad) begin
                exp_ce[idx]++;
            end else begin
                exp_mem[idx][a] = data;
                exp_wr[idx] = (exp_wr[idx] + 1) % 65536;
            end
        end
        check_counts(idx);
    endtask

    task automatic do_read(input int idx, input int addr, input int stop_at);
        logic [7:0]  cmd, rx_crc;
        logic [31:0] rx_data;
        logic        rx_any;
        int          a;
        a = addr & 32'(amask(idx));
        cmd = {1'b1, 7'($urandom)};
        cmd = (cmd & ~amask(idx)) | 8'(a);
        exp_q.push_back(exp_mem[idx][a]);
        exp_q.push_back(32'(crc8(8'hFF, 64'(exp_mem[idx][a]), DW[idx])));
        spi_frame(idx, cmd, 32'd0, 8'd0, stop_at, 1'b0, rx_data, rx_crc, rx_any);
        if (stop_at >= 16 + DW[idx]) begin
            check($sformatf("i%0d rd_data a%0d", idx, a), rx_data, exp_q.pop_front());
            check($sformatf("i%0d rd_crc a%0d", idx, a), 32'(rx_crc), exp_q.pop_front());
            exp_fd[idx]++;
        end else begin
            exp_q.delete();
            exp_ab[idx]++;
        end
        check_counts(idx);
    endtask

    initial begin
        logic [31:0] d;
        logic [7:0]  rc;
        logic        ra;
        int          a;
        int          nb;
        rstn = 1'b0;
        for (int i = 0; i < NI; i++) begin
            sck_v[i]  = CP_OL[i];
            csn_v[i]  = 1'b1;
            mosi_v[i] = 1'b0;
            exp_fd[i] = 0;
            exp_ce[i] = 0;
            exp_ab[i] = 0;
        end
        model_reset();
        repeat (5) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("i%0d reset_miso", i),    32'(miso_v[i]),    32'd0);
            check($sformatf("i%0d reset_miso_oe", i), 32'(miso_oe_v[i]), 32'd0);
            check($sformatf("i%0d reset_state", i),   32'(dbg_v[i]),     32'd0);
            check($sformatf("i%0d reset_wr_cnt", i),  32'(wrc_v[i]),     32'd0);
        end
        rstn = 1'b1;
        repeat (5) @(negedge clk);

        for (int i = 0; i < NI; i++) begin
            nb = 16 + DW[i];
            // Reset contents, then a good write read back.
            do_read(i, 0, 999);
            a = (i == 0) ? 5 : ((AW[i] == 7) ? 127 : 5);
            d = (i == 0) ? 32'h0012_3456 : $urandom;
            do_write(i, a, d, 1'b0, 999);
            do_read(i, a, 999);
            // Corrupted CRC must leave the word alone.
            do_write(i, 3, 32'h00AB_CDEF, 1'b1, 999);
            do_read(i, 3, 999);
            // csn raised after 12 bits of a write.
            do_write(i, 7, $urandom, 1'b0, 12);
            do_read(i, 7, 999);
            // Randomised mix of reads, writes, bad CRCs and aborts.
            repeat (8) begin
                int stop;
                a = $urandom_range(0, 127);
                stop = ($urandom_range(0, 5) == 0) ? $urandom_range(1, nb - 1) : 999;
                if ($urandom_range(0, 1) == 1)
                    do_write(i, a, $urandom, ($urandom_range(0, 3) == 0), stop);
                else
                    do_read(i, a, stop);
            end
        end

        // Reset in the middle of a read: everything returns to reset values.
        a = 5;
        spi_frame(0, {1'b1, 7'd5}, 32'd0, 8'd0, 20, 1'b1, d, rc, ra);
        model_reset();
        for (int i = 0; i < NI; i++) begin
            check_counts(i);
            do_read(i, (AW[i] == 7) ? 127 : 5, 999);
        end
        do_write(0, a, $urandom, 1'b0, 999);
        do_read(0, a, 999);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
